// File: rtl/pill_schedule_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pill_schedule_tracker: per-pill hourly dose countdown with due,      |
// | overdue and saturating missed-dose tracking.   Revision: 1.0         |
// +----------------------------------------------------------------------+
module pill_schedule_tracker #(
  parameter int NUM_PILLS = 3,
  parameter int DUR_W     = 4,
  parameter int CLOCK_W   = 24,
  parameter int HOUR_LSB  = 16,
  parameter int HOUR_W    = 4,
  parameter int MISS_W    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  state,
  input  logic [NUM_PILLS*DUR_W-1:0]  schedule,
  input  logic [CLOCK_W-1:0]          time_in,
  input  logic [NUM_PILLS-1:0]        taken,
  input  logic                        clear_missed,
  output logic [NUM_PILLS*DUR_W-1:0]  remaining,
  output logic [NUM_PILLS-1:0]        due,
  output logic [NUM_PILLS-1:0]        overdue,
  output logic [NUM_PILLS-1:0]        due_pulse,
  output logic [NUM_PILLS*MISS_W-1:0] missed_count,
  output logic                        any_alert
);

  localparam logic [DUR_W-1:0]  c_REM_ONE  = DUR_W'(1);
  localparam logic [DUR_W-1:0]  c_REM_ZERO = '0;
  localparam logic [MISS_W-1:0] c_MISS_MAX = {MISS_W{1'b1}};

  logic [HOUR_W-1:0] w_hour;
  logic [HOUR_W-1:0] r_hour_prev;
  logic              r_hour_valid;
  logic              w_tick;
  logic              w_load;
  logic              w_run;

  assign w_hour = time_in[HOUR_LSB +: HOUR_W];
  assign w_tick = r_hour_valid && (w_hour != r_hour_prev);
  assign w_load = (state <= 4'd2);
  assign w_run  = (state == 4'd3);

  // Hour tracking runs in every state so that leaving HOLD/LOAD never sees a stale hour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hour_prev  <= '0;
      r_hour_valid <= 1'b0;
    end else begin
      r_hour_prev  <= w_hour;
      r_hour_valid <= 1'b1;
    end
  end

  logic [NUM_PILLS-1:0] r_due;
  logic [NUM_PILLS-1:0] r_overdue;
  logic [NUM_PILLS-1:0] r_due_pulse;

  for (genvar i = 0; i < NUM_PILLS; i++) begin : g_pill
    logic [DUR_W-1:0]  w_sched;
    logic [DUR_W-1:0]  r_rem;
    logic [MISS_W-1:0] r_miss;
    logic              w_enabled;
    logic              w_miss_inc;

    assign w_sched    = schedule[i*DUR_W +: DUR_W];
    assign w_enabled  = (w_sched != c_REM_ZERO);
    assign w_miss_inc = w_run && w_enabled && !taken[i] && w_tick && (r_rem == c_REM_ZERO);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rem          <= '0;
        r_due[i]       <= 1'b0;
        r_overdue[i]   <= 1'b0;
        r_due_pulse[i] <= 1'b0;
      end else begin
        r_due_pulse[i] <= 1'b0;
        if (w_load) begin
          r_rem        <= w_sched;
          r_due[i]     <= 1'b0;
          r_overdue[i] <= 1'b0;
        end else if (w_run) begin
          if (!w_enabled) begin
            r_rem        <= '0;
            r_due[i]     <= 1'b0;
            r_overdue[i] <= 1'b0;
          end else if (taken[i]) begin
            r_rem        <= w_sched;
            r_due[i]     <= 1'b0;
            r_overdue[i] <= 1'b0;
          end else if (w_tick) begin
            if (r_rem > c_REM_ONE) begin
              r_rem <= r_rem - c_REM_ONE;
            end else if (r_rem == c_REM_ONE) begin
              r_rem          <= '0;
              r_due[i]       <= 1'b1;
              r_due_pulse[i] <= !r_due[i];
            end else begin
              // Missed a whole hour while due: restart the interval, keep due asserted.
              r_overdue[i] <= 1'b1;
              r_rem        <= w_sched;
            end
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_miss <= '0;
      end else if (clear_missed) begin
        r_miss <= '0;
      end else if (w_miss_inc && (r_miss != c_MISS_MAX)) begin
        r_miss <= r_miss + MISS_W'(1);
      end
    end

    assign remaining[i*DUR_W +: DUR_W]     = r_rem;
    assign missed_count[i*MISS_W +: MISS_W] = r_miss;
  end

  assign due       = r_due;
  assign overdue   = r_overdue;
  assign due_pulse = r_due_pulse;
  assign any_alert = |r_overdue;

endmodule
`default_nettype wire

// File: tb/tb_pill_schedule_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pill_schedule_tracker: directed self-checking bench for           |
// | pill_schedule_tracker (default parameters).      Revision: 1.0       |
// +----------------------------------------------------------------------+
module tb_pill_schedule_tracker;

  logic        clk;
  logic        reset_n;
  logic [3:0]  state;
  logic [11:0] schedule;
  logic [23:0] time_in;
  logic [2:0]  taken;
  logic        clear_missed;
  logic [11:0] remaining;
  logic [2:0]  due;
  logic [2:0]  overdue;
  logic [2:0]  due_pulse;
  logic [11:0] missed_count;
  logic        any_alert;

  int n_checks = 0;
  int n_fail   = 0;
  int hour     = 0;

  pill_schedule_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .state        (state),
    .schedule     (schedule),
    .time_in      (time_in),
    .taken        (taken),
    .clear_missed (clear_missed),
    .remaining    (remaining),
    .due          (due),
    .overdue      (overdue),
    .due_pulse    (due_pulse),
    .missed_count (missed_count),
    .any_alert    (any_alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hour(input int h);
    hour    = h % 16;
    time_in = {4'h0, 4'(hour), 16'h0000};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    state        = 4'd0;
    schedule     = 12'h000;
    taken        = 3'b000;
    clear_missed = 1'b0;
    set_hour(5);
    step();
    check("rst_remaining", 32'(remaining), 32'h0);
    check("rst_flags", {due, overdue, due_pulse, any_alert}, 32'h0);
    check("rst_missed", 32'(missed_count), 32'h0);

    // LOAD {2,3,1}; hour changes are ignored while loading
    reset_n  = 1'b1;
    schedule = 12'h231;
    step();
    step();
    check("load_remaining", 32'(remaining), 32'h231);
    state = 4'd3;
    step();
    check("run_no_tick", 32'(remaining), 32'h231);

    set_hour(6);
    step();
    check("t1_remaining", 32'(remaining), 32'h120);
    check("t1_due", 32'(due), 32'h1);
    check("t1_pulse", 32'(due_pulse), 32'h1);
    step();
    check("t1_pulse_width", 32'(due_pulse), 32'h0);

    set_hour(7);
    step();
    check("t2_remaining", 32'(remaining), 32'h011);
    check("t2_overdue", 32'(overdue), 32'h1);
    check("t2_alert", 32'(any_alert), 32'h1);
    check("t2_missed", 32'(missed_count), 32'h001);
    check("t2_due", 32'(due), 32'h5);
    check("t2_pulse", 32'(due_pulse), 32'h4);

    // taken[0] together with a tick: reload wins for pill 0
    taken = 3'b001;
    set_hour(8);
    step();
    taken = 3'b000;
    check("t3_remaining", 32'(remaining), 32'h201);
    check("t3_due", 32'(due), 32'h6);
    check("t3_overdue", 32'(overdue), 32'h4);
    check("t3_missed", 32'(missed_count), 32'h101);

    // Pill 1 disabled
    state    = 4'd0;
    schedule = 12'h201;
    step();
    check("l2_remaining", 32'(remaining), 32'h201);
    check("l2_flags", {due, overdue, any_alert}, 32'h0);
    check("l2_missed_held", 32'(missed_count), 32'h101);
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    check("clear_missed", 32'(missed_count), 32'h0);
    state = 4'd3;
    taken = 3'b010;
    set_hour(9);
    step();
    check("d1_remaining", 32'(remaining), 32'h100);
    check("d1_due", 32'(due), 32'h1);
    set_hour(10);
    step();
    taken = 3'b000;
    check("d2_remaining", 32'(remaining), 32'h001);
    check("d2_due", 32'(due), 32'h5);
    check("d2_overdue", 32'(overdue), 32'h1);
    check("d2_missed", 32'(missed_count), 32'h001);

    // Saturation: interval 1, many ticks with no dose taken
    state    = 4'd0;
    schedule = 12'h001;
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    state = 4'd3;
    for (int k = 0; k < 40; k++) begin
      set_hour(hour + 1);
      step();
    end
    check("sat_missed", 32'(missed_count), 32'h00F);
    set_hour(hour + 1);
    step();
    check("sat_remaining", 32'(remaining), 32'h000);
    set_hour(hour + 1);
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    check("clear_over_inc", 32'(missed_count), 32'h0);
    check("sat_overdue", 32'(overdue), 32'h1);

    // Wrap 15 -> 0 is a single tick
    state    = 4'd0;
    schedule = 12'h002;
    set_hour(15);
    step();
    state = 4'd3;
    step();
    check("wrap_pre", 32'(remaining), 32'h002);
    set_hour(0);
    step();
    check("wrap_tick", 32'(remaining), 32'h001);
    set_hour(3);
    step();
    check("due_again_pulse", 32'(due_pulse), 32'h1);

    // HOLD freezes everything but forces due_pulse low
    state = 4'd7;
    set_hour(4);
    step();
    check("hold_pulse", 32'(due_pulse), 32'h0);
    check("hold_remaining", 32'(remaining), 32'h000);
    check("hold_due", 32'(due), 32'h1);
    set_hour(5);
    step();
    check("hold_overdue", 32'(overdue), 32'h0);
    check("hold_missed", 32'(missed_count), 32'h0);
    state = 4'd3;
    step();
    check("post_hold_no_tick", {remaining, due, overdue}, {12'h000, 3'b001, 3'b000});

    // Asynchronous reset mid-RUN
    set_hour(6);
    step();
    check("pre_rst_overdue", 32'(overdue), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_remaining", 32'(remaining), 32'h0);
    check("async_rst_flags", {due, overdue, due_pulse, any_alert}, 32'h0);
    check("async_rst_missed", 32'(missed_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
